// File: rtl/multicore_dram_arbiter_pkg.sv
// Shared definitions for the multi-core DRAM arbiter.
//   arb_state_t : arbiter FSM state encoding
//   DEF_ADDR_W  : default DRAM word-address width
//   DEF_DATA_W  : default DRAM data width
//   clog2()     : index width for a core count, never less than 1 bit
package multicore_dram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/multicore_dram_arbiter_rr_priority_picker.sv
// Round-robin priority picker (combinational).
// Scans the eligible vector starting at rr_ptr, wrapping at N, and reports
// the first set bit.
//   eligible : N-bit candidate vector
//   rr_ptr   : index where the scan starts (0..N-1)
//   valid    : at least one candidate is eligible
//   winner   : index of the selected candidate
module rr_priority_picker
  import multicore_dram_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  // One extra bit so rr_ptr + offset cannot overflow before the wrap.
  logic [IDX_W:0] cand;

  // Scan from the farthest offset down to zero so the nearest eligible
  // index (relative to rr_ptr) is the last one written.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N)) cand = cand - (IDX_W + 1)'(N);
      if (eligible[cand[IDX_W-1:0]]) begin
        valid  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/multicore_dram_arbiter.sv
// Multi-core DRAM arbiter: shares one single-port DRAM among N_CORES cores
// with a round-robin request/ack handshake, one access in flight at a time.
//   clk, rst_n  : system clock, synchronous active-low reset
//   core_req    : per-core request, held until core_ack
//   core_we     : per-core write enable (1 = write)
//   core_addr   : packed per-core addresses, core i at [i*ADDR_W +: ADDR_W]
//   core_wdata  : packed per-core write data, core i at [i*DATA_W +: DATA_W]
//   core_end    : per-core End flag (sticky once seen)
//   core_ack    : one-cycle completion pulse to the served core
//   core_rdata  : read data, valid with the ack of a read
//   dram_addr, dram_data, dram_we : DRAM command outputs
//   dram_q      : DRAM read data, RD_LAT cycles after the address
//   dram_end    : all cores have ended
//
// state  | meaning
// ARB    | idle; pick next eligible core, latch its transaction
// ACCESS | drive address/data to DRAM, write strobe for one cycle
// WAIT   | read in progress; down-count latency, capture dram_q at zero
// RESP   | pulse core_ack to the winner
module multicore_dram_arbiter
  import multicore_dram_arbiter_pkg::*;
#(
  parameter int N_CORES = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CORES-1:0]          core_req,
  input  logic [N_CORES-1:0]          core_we,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  input  logic [N_CORES*DATA_W-1:0]   core_wdata,
  input  logic [N_CORES-1:0]          core_end,
  output logic [N_CORES-1:0]          core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           dram_addr,
  output logic [DATA_W-1:0]           dram_data,
  output logic                        dram_we,
  input  logic [DATA_W-1:0]           dram_q,
  output logic                        dram_end
);

  localparam int IDX_W = clog2(N_CORES);
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CORES - 1);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   winner_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   lat_cnt;
  logic [N_CORES-1:0] ended;
  logic [N_CORES-1:0] eligible;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  // A core raising End in the same cycle as a request is already treated
  // as finished, so that request never wins.
  assign eligible = core_req & ~ended & ~core_end;

  rr_priority_picker #(
    .N     (N_CORES),
    .IDX_W (IDX_W)
  ) u_picker (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .valid    (pick_valid),
    .winner   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB;
      rr_ptr     <= '0;
      ended      <= '0;
      winner_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_cnt    <= '0;
      core_rdata <= '0;
      dram_end   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ended    <= ended | core_end;
      dram_end <= &ended;
      case (state)
        ARB: begin
          if (pick_valid) begin
            winner_q <= pick_idx;
            we_q     <= core_we[pick_idx];
            addr_q   <= core_addr[pick_idx*ADDR_W +: ADDR_W];
            wdata_q  <= core_wdata[pick_idx*DATA_W +: DATA_W];
            // Explicit wrap keeps non-power-of-two core counts in range.
            rr_ptr   <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
          end
        end
        ACCESS: lat_cnt <= LAT_LOAD;
        WAIT: begin
          if (lat_cnt == '0) core_rdata <= dram_q;
          else               lat_cnt    <= lat_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    core_ack  = '0;
    dram_addr = '0;
    dram_data = '0;
    dram_we   = 1'b0;
    case (state)
      ARB: begin
        if (pick_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        dram_addr = addr_q;
        dram_data = wdata_q;
        dram_we   = we_q;
        state_nxt = we_q ? RESP : WAIT;
      end
      WAIT: begin
        dram_addr = addr_q;
        if (lat_cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        core_ack[winner_q] = 1'b1;
        state_nxt          = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

endmodule

// File: tb/tb_multicore_dram_arbiter.sv
module tb_multicore_dram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Instance A: 3 cores, RD_LAT = 2
  logic        a_rst_n;
  logic [2:0]  a_req, a_we, a_end, a_ack;
  logic [35:0] a_addr;
  logic [95:0] a_wdata;
  logic [31:0] a_rdata, a_dram_data, a_dram_q;
  logic [11:0] a_dram_addr;
  logic        a_dram_we, a_dram_end;

  multicore_dram_arbiter #(.N_CORES(3), .ADDR_W(12), .DATA_W(32), .RD_LAT(2)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .core_req(a_req), .core_we(a_we),
    .core_addr(a_addr), .core_wdata(a_wdata), .core_end(a_end),
    .core_ack(a_ack), .core_rdata(a_rdata), .dram_addr(a_dram_addr),
    .dram_data(a_dram_data), .dram_we(a_dram_we), .dram_q(a_dram_q),
    .dram_end(a_dram_end)
  );

  logic [31:0] a_mem [0:4095];
  logic [31:0] a_stage;
  always @(posedge clk) begin
    if (a_dram_we) a_mem[a_dram_addr] <= a_dram_data;
    a_stage  <= a_mem[a_dram_addr];
    a_dram_q <= a_stage;
  end

  // Instance B: 2 cores, RD_LAT = 1
  logic        b_rst_n;
  logic [1:0]  b_req, b_we, b_end, b_ack;
  logic [23:0] b_addr;
  logic [63:0] b_wdata;
  logic [31:0] b_rdata, b_dram_data, b_dram_q;
  logic [11:0] b_dram_addr;
  logic        b_dram_we, b_dram_end;

  multicore_dram_arbiter #(.N_CORES(2), .ADDR_W(12), .DATA_W(32), .RD_LAT(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .core_req(b_req), .core_we(b_we),
    .core_addr(b_addr), .core_wdata(b_wdata), .core_end(b_end),
    .core_ack(b_ack), .core_rdata(b_rdata), .dram_addr(b_dram_addr),
    .dram_data(b_dram_data), .dram_we(b_dram_we), .dram_q(b_dram_q),
    .dram_end(b_dram_end)
  );

  logic [31:0] b_mem [0:4095];
  always @(posedge clk) begin
    if (b_dram_we) b_mem[b_dram_addr] <= b_dram_data;
    b_dram_q <= b_mem[b_dram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ack_idx(input logic [2:0] ack);
    case (ack)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 7;
    endcase
  endfunction

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    repeat (3) tick();
    n_total++;
    if (a_ack !== 3'b000) $display("FAIL reset_ack: got %b expected 000", a_ack); else n_pass++;
    n_total++;
    if ({a_dram_we, a_dram_addr, a_dram_data} !== 45'h0)
      $display("FAIL reset_dram: got we=%b addr=%h data=%h expected zeros", a_dram_we, a_dram_addr, a_dram_data);
    else n_pass++;
    n_total++;
    if (a_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", a_rdata); else n_pass++;
    n_total++;
    if ({a_dram_end, b_dram_end} !== 2'b00) $display("FAIL reset_end: got %b expected 00", {a_dram_end, b_dram_end}); else n_pass++;
    n_total++;
    if (b_ack !== 2'b00) $display("FAIL reset_ack_b: got %b expected 00", b_ack); else n_pass++;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int we_cnt, ack_cyc;
    logic [2:0] ack_val;
    we_cnt = 0; ack_cyc = -1; ack_val = '0;
    a_req = 3'b001; a_we = 3'b001;
    a_addr[11:0] = 12'h005; a_wdata[31:0] = 32'hDEADBEEF;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        a_addr[11:0] = 12'h0FF; a_wdata[31:0] = 32'h0;
      end
      if (a_dram_we) begin
        we_cnt++;
        n_total++;
        if (a_dram_addr !== 12'h005) $display("FAIL write_addr: got %h expected 005", a_dram_addr); else n_pass++;
        n_total++;
        if (a_dram_data !== 32'hDEADBEEF) $display("FAIL write_data: got %h expected deadbeef", a_dram_data); else n_pass++;
      end
      if (a_ack !== 3'b000 && ack_cyc < 0) begin
        ack_cyc = c; ack_val = a_ack; a_req = 3'b000;
      end
    end
    a_we = 3'b000;
    n_total++;
    if (we_cnt != 1) $display("FAIL write_we_cycles: got %0d expected 1", we_cnt); else n_pass++;
    n_total++;
    if (ack_cyc != 2) $display("FAIL write_ack_latency: got %0d expected 2", ack_cyc); else n_pass++;
    n_total++;
    if (ack_val !== 3'b001) $display("FAIL write_ack_vec: got %b expected 001", ack_val); else n_pass++;
  endtask

  task automatic test_read_lat2();
    int ack_cyc, we_seen;
    logic [2:0]  ack_val;
    logic [31:0] rd;
    ack_cyc = -1; we_seen = 0; ack_val = '0; rd = '0;
    a_req = 3'b010; a_we = 3'b000; a_addr[23:12] = 12'h005;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (a_dram_we) we_seen++;
      if (a_ack !== 3'b000 && ack_cyc < 0) begin
        ack_cyc = c; ack_val = a_ack; rd = a_rdata; a_req = 3'b000;
      end
    end
    n_total++;
    if (ack_cyc != 4) $display("FAIL read_ack_latency: got %0d expected 4", ack_cyc); else n_pass++;
    n_total++;
    if (ack_val !== 3'b010) $display("FAIL read_ack_vec: got %b expected 010", ack_val); else n_pass++;
    n_total++;
    if (rd !== 32'hDEADBEEF) $display("FAIL read_data: got %h expected deadbeef", rd); else n_pass++;
    n_total++;
    if (we_seen != 0) $display("FAIL read_no_we: got %0d expected 0", we_seen); else n_pass++;
    n_total++;
    if (a_rdata !== 32'hDEADBEEF) $display("FAIL read_data_hold: got %h expected deadbeef", a_rdata); else n_pass++;
  endtask

  task automatic test_contention();
    int idx [6];
    int cyc [6];
    int n_ack;
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin idx[i] = -1; cyc[i] = -1; end
    a_rst_n = 1'b0;
    a_req = 3'b111; a_we = 3'b111;
    a_addr  = {12'h012, 12'h011, 12'h010};
    a_wdata = {32'h102, 32'h101, 32'h100};
    tick();
    a_rst_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (a_ack !== 3'b000) begin
        if (n_ack < 6) begin idx[n_ack] = ack_idx(a_ack); cyc[n_ack] = c; end
        n_ack++;
        if (n_ack == 6) a_req = 3'b000;
      end
    end
    a_we = 3'b000;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (idx[i] != i % 3) $display("FAIL contention_order[%0d]: got %0d expected %0d", i, idx[i], i % 3); else n_pass++;
      n_total++;
      if (cyc[i] != 2 + 3 * i) $display("FAIL contention_cycle[%0d]: got %0d expected %0d", i, cyc[i], 2 + 3 * i); else n_pass++;
    end
    n_total++;
    if (n_ack != 6) $display("FAIL contention_ack_count: got %0d expected 6", n_ack); else n_pass++;
    n_total++;
    if (a_rdata !== 32'h0) $display("FAIL contention_rdata_unchanged: got %h expected 0", a_rdata); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int ack_cyc, ack_seen;
    logic [2:0] ack_val;
    ack_cyc = -1; ack_seen = 0; ack_val = '0;
    a_req = 3'b010; a_we = 3'b000; a_addr[23:12] = 12'h010;
    tick();
    if (a_ack !== 3'b000) ack_seen++;
    tick();
    if (a_ack !== 3'b000) ack_seen++;
    n_total++;
    if ({a_dram_we, a_dram_addr} !== {1'b0, 12'h010})
      $display("FAIL wait_addr_hold: got we=%b addr=%h expected we=0 addr=010", a_dram_we, a_dram_addr);
    else n_pass++;
    a_rst_n = 1'b0; a_req = 3'b000;
    tick();
    if (a_ack !== 3'b000) ack_seen++;
    n_total++;
    if (ack_seen != 0) $display("FAIL midreset_no_ack: got %0d acks expected 0", ack_seen); else n_pass++;
    n_total++;
    if ({a_dram_we, a_dram_addr, a_dram_data, a_rdata} !== 77'h0)
      $display("FAIL midreset_outputs: got we=%b addr=%h data=%h rdata=%h expected zeros", a_dram_we, a_dram_addr, a_dram_data, a_rdata);
    else n_pass++;
    a_rst_n = 1'b1;
    a_req = 3'b110; a_we = 3'b110;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (a_ack !== 3'b000 && ack_cyc < 0) begin
        ack_cyc = c; ack_val = a_ack; a_req = 3'b000;
      end
    end
    a_we = 3'b000;
    n_total++;
    if (ack_val !== 3'b010) $display("FAIL midreset_first_grant: got %b expected 010", ack_val); else n_pass++;
    n_total++;
    if (ack_cyc != 2) $display("FAIL midreset_grant_latency: got %0d expected 2", ack_cyc); else n_pass++;
  endtask

  task automatic test_req_and_end();
    int ack_any, we_any;
    ack_any = 0; we_any = 0;
    a_req = 3'b100; a_we = 3'b100; a_end = 3'b100;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) a_end = 3'b000;
      if (a_ack !== 3'b000) ack_any++;
      if (a_dram_we) we_any++;
    end
    n_total++;
    if (ack_any != 0) $display("FAIL req_end_no_ack: got %0d expected 0", ack_any); else n_pass++;
    n_total++;
    if (we_any != 0) $display("FAIL req_end_no_access: got %0d expected 0", we_any); else n_pass++;
    a_req = 3'b000; a_we = 3'b000; a_end = 3'b011;
    tick();
    a_end = 3'b000;
    n_total++;
    if (a_dram_end !== 1'b0) $display("FAIL req_end_dram_end_early: got %b expected 0", a_dram_end); else n_pass++;
    tick();
    n_total++;
    if (a_dram_end !== 1'b1) $display("FAIL req_end_ended_bit: got %b expected 1", a_dram_end); else n_pass++;
  endtask

  task automatic test_end_aggregation();
    int pre_cyc, ack0_cnt, ack1_cyc, early_end, late_low;
    logic [31:0] rd;
    pre_cyc = -1; ack0_cnt = 0; ack1_cyc = -1; early_end = 0; late_low = 0; rd = '0;
    b_req = 2'b10; b_we = 2'b10; b_addr[23:12] = 12'h007; b_wdata[63:32] = 32'h12345678;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (b_ack !== 2'b00 && pre_cyc < 0) begin pre_cyc = c; b_req = 2'b00; end
    end
    n_total++;
    if (pre_cyc != 2) $display("FAIL b_write_latency: got %0d expected 2", pre_cyc); else n_pass++;
    b_rst_n = 1'b0;
    tick();
    b_rst_n = 1'b1;
    for (int k = 0; k <= 27; k++) begin
      b_end = (k == 10) ? 2'b01 : (k == 20) ? 2'b10 : 2'b00;
      if (k == 11) begin
        b_req = 2'b11; b_we = 2'b01; b_addr[23:12] = 12'h007;
      end
      if (b_ack[0]) ack0_cnt++;
      if (b_ack[1] && ack1_cyc < 0) begin
        ack1_cyc = k; rd = b_rdata; b_req[1] = 1'b0;
      end
      if (k <= 21 && b_dram_end) early_end++;
      if (k >= 22 && !b_dram_end) late_low++;
      tick();
    end
    b_req = 2'b00; b_we = 2'b00;
    n_total++;
    if (ack0_cnt != 0) $display("FAIL end_core0_ignored: got %0d acks expected 0", ack0_cnt); else n_pass++;
    n_total++;
    if (ack1_cyc != 14) $display("FAIL end_core1_read_cycle: got %0d expected 14", ack1_cyc); else n_pass++;
    n_total++;
    if (rd !== 32'h12345678) $display("FAIL end_core1_read_data: got %h expected 12345678", rd); else n_pass++;
    n_total++;
    if (early_end != 0) $display("FAIL dram_end_early: got %0d high cycles expected 0", early_end); else n_pass++;
    n_total++;
    if (late_low != 0) $display("FAIL dram_end_held: got %0d low cycles expected 0", late_low); else n_pass++;
  endtask

  initial begin
    a_rst_n = 1'b0; a_req = '0; a_we = '0; a_end = '0; a_addr = '0; a_wdata = '0;
    b_rst_n = 1'b0; b_req = '0; b_we = '0; b_end = '0; b_addr = '0; b_wdata = '0;
    test_reset();
    test_single_write();
    test_read_lat2();
    test_contention();
    test_reset_mid_read();
    test_req_and_end();
    test_end_aggregation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicore_dram_arbiter.md
Name: multicore_dram_arbiter

Overview:
- Shares the single-port DRAM among N_CORES processor cores in the multi-core top level.
- Each core keeps its existing memory-side signals (address, write data, write enable, End) and adds a request/acknowledge handshake.
- Arbitration is round-robin; one DRAM access is in flight at a time.
- Read data returns to the winning core after the DRAM read latency.
- DRAM End is asserted only when every core has finished.

Parameters:
- N_CORES, 2: number of cores sharing DRAM (2..8).
- ADDR_W, 12: DRAM word-address width.
- DATA_W, 32: DRAM data width.
- RD_LAT, 1: cycles from DRAM address valid to q valid (1..4).

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- core_req  in  N_CORES  per-core access request; held until the matching core_ack.
- core_we  in  N_CORES  per-core write enable; 1 = write, 0 = read.
- core_addr  in  N_CORES*ADDR_W  packed addresses; core i occupies slice [i*ADDR_W +: ADDR_W].
- core_wdata  in  N_CORES*DATA_W  packed write data, same slicing.
- core_end  in  N_CORES  per-core End flag.
- core_ack  out  N_CORES  one-cycle completion pulse to the winning core.
- core_rdata  out  DATA_W  read data; valid when the matching core_ack is high after a read.
- dram_addr  out  ADDR_W  DRAM address.
- dram_data  out  DATA_W  DRAM write data.
- dram_we  out  1  DRAM write enable.
- dram_q  in  DATA_W  DRAM read data.
- dram_end  out  1  all-cores-finished indication to DRAM.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=ARB; rr_ptr=0; ended mask=0.
  - core_ack=0, core_rdata=0, dram_addr=0, dram_data=0, dram_we=0, dram_end=0.
  - A reset mid-transaction aborts the transaction with no ack. An aborted write is not guaranteed to be suppressed if dram_we was already high.
- FSM states: ARB, ACCESS, WAIT, RESP.
- ARB:
  - Eligible set = core_req & ~ended.
  - If empty, stay in ARB with all outputs idle.
  - Otherwise pick the first eligible core scanning from rr_ptr upward with wrap-around.
  - Latch the winner's index, we, addr and wdata into registers.
  - Set rr_ptr = (winner+1) mod N_CORES, then go to ACCESS.
- ACCESS (one cycle):
  - dram_addr and dram_data are driven from the latched values.
  - dram_we = latched we, high for exactly this cycle.
  - Write: go to RESP.
  - Read: go to WAIT and load the latency counter with RD_LAT-1.
- WAIT:
  - dram_addr stays held and dram_we=0.
  - The counter decrements each cycle; at 0, capture dram_q into core_rdata and go to RESP.
  - When RD_LAT=1, WAIT lasts exactly one cycle.
- RESP (one cycle):
  - core_ack[winner]=1, all other ack bits 0; next state is ARB.
  - core_rdata holds its value until the next read capture.
  - For writes, core_rdata is unchanged.
- Latency from the ARB grant cycle to the ack cycle:
  - write: 2 cycles (ARB→ACCESS→RESP);
  - read: 2+RD_LAT cycles.
  - Back-to-back transactions cost 3 and 3+RD_LAT cycles each.
- A core deasserting core_req before its ack is a protocol violation; the latched transaction completes anyway.
- Changes to address or data after grant are ignored, because values are latched.
- End handling:
  - ended[i] is set when core_end[i]=1 and stays set until reset.
  - Ended cores are excluded from arbitration.
  - dram_end = &ended, registered, so it rises one cycle after the last end bit is captured.
  - If core_end and core_req arrive in the same cycle for core i, the request is ignored.
  - dram_end is held high until reset.
- Simultaneous requests from all cores are served in rotation starting at rr_ptr, so none is starved. Worst-case wait is (N_CORES-1) transactions.
- Width rules:
  - Slice selection uses winner*ADDR_W and winner*DATA_W; no arithmetic on data.
  - rr_ptr and winner are clog2(N_CORES) bits; the wrap from N_CORES-1 goes to 0 explicitly, which also covers non-power-of-two counts.

Decomposition:
- Shared package:
  - FSM state encoding (ARB=0, ACCESS=1, WAIT=2, RESP=3).
  - Default widths ADDR_W=12 and DATA_W=32.
  - Index width function clog2.
- One sub-module: rr_priority_picker, purely combinational.
  - Inputs: eligible vector and rr_ptr.
  - Outputs: valid and winner index.

Test Plan:
- Single write: core0 request, we=1, addr=0x005, wdata=0xDEADBEEF.
  - Expect dram_we high for exactly one cycle with addr 0x005 and data 0xDEADBEEF.
  - Expect core_ack[0] two cycles after grant.
- Read with RD_LAT=2: core1 reads addr 0x005 from a DRAM model preloaded with 0xDEADBEEF.
  - Expect core_rdata=0xDEADBEEF with core_ack[1] at grant+4.
- Contention, N_CORES=3: all three request continuously from reset.
  - Expect grant order 0,1,2,0,1,2.
  - Expect each ack separated by 3 cycles (writes) and no core served twice in a row.
- End aggregation, N_CORES=2: core0 end pulses at cycle 10, then core1 requests; core1 end pulses at cycle 20.
  - Expect core0 requests ignored after cycle 10.
  - Expect dram_end=0 until cycle 21, then 1 and held.
- Reset mid-read: rst_n=0 during WAIT.
  - Expect no ack, all outputs at reset values on the next edge, and rr_ptr=0.
  - The next request from core1 is granted first.
- Simultaneous request and end, same core, same cycle.
  - Expect no grant, no DRAM access, and the ended bit set.
